// File: rtl/random_delay_if.sv
// Handshake bundle between the start-light sequencer and the random hold-time
// generator: timing strobes and start level in, expiry/status and captured delay out.
interface random_delay_if #(
    parameter int LFSR_W = 7
);
    logic              tick_ms;
    logic              en_lfsr;
    logic              start_delay;
    logic              time_out;
    logic              busy;
    logic [LFSR_W-1:0] delay_val;

    modport master (
        output tick_ms,
        output en_lfsr,
        output start_delay,
        input  time_out,
        input  busy,
        input  delay_val
    );

    modport slave (
        input  tick_ms,
        input  en_lfsr,
        input  start_delay,
        output time_out,
        output busy,
        output delay_val
    );
endinterface

// File: rtl/random_delay.sv
// Random hold-time generator. A free-running LFSR is sampled on the rising edge
// of start_delay; the sample times SCALE millisecond ticks later time_out rises
// and stays high until the sequencer drops start_delay.
module random_delay #(
    parameter int                LFSR_W  = 7,
    parameter logic [LFSR_W-1:0] SEED    = 7'h01,
    parameter int                SCALE   = 16,
    parameter int                SCALE_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    random_delay_if.slave        bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Fibonacci step for x^7+x^6+1: shift left, feed back the two top taps.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], v[LFSR_W-1] ^ v[LFSR_W-2]};
    endfunction

    localparam logic [SCALE_W-1:0] SUB_LAST = SCALE_W'(SCALE - 1);
    localparam logic [LFSR_W-1:0]  UNIT_ONE = LFSR_W'(1);

    state_t              state_r;
    state_t              state_s;
    logic [LFSR_W-1:0]   lfsr_r;
    logic                start_d_r;
    logic                start_rise_s;
    logic [LFSR_W-1:0]   units_r;
    logic [LFSR_W-1:0]   units_s;
    logic [SCALE_W-1:0]  sub_r;
    logic [SCALE_W-1:0]  sub_s;
    logic                time_out_r;
    logic                time_out_s;
    logic                busy_r;
    logic                busy_s;
    logic [LFSR_W-1:0]   delay_val_r;
    logic [LFSR_W-1:0]   delay_val_s;

    assign start_rise_s  = bus.start_delay & ~start_d_r;
    assign bus.time_out  = time_out_r;
    assign bus.busy      = busy_r;
    assign bus.delay_val = delay_val_r;

    // LFSR advances whenever enabled, independent of the controller state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_r <= SEED;
        end else if (bus.en_lfsr) begin
            lfsr_r <= lfsr_next(lfsr_r);
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

    // Delayed copy of start_delay for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_d_r <= 1'b0;
        end else begin
            start_d_r <= bus.start_delay;
        end
    end

    // Next-state and next-output logic for the IDLE/COUNT/DONE controller.
    always_comb begin
        state_s     = state_r;
        units_s     = units_r;
        sub_s       = sub_r;
        time_out_s  = time_out_r;
        busy_s      = busy_r;
        delay_val_s = delay_val_r;

        case (state_r)
            ST_IDLE: begin
                time_out_s = 1'b0;
                busy_s     = 1'b0;
                if (start_rise_s) begin
                    // Capture the pre-advance value even if en_lfsr is high now.
                    units_s     = lfsr_r;
                    delay_val_s = lfsr_r;
                    sub_s       = {SCALE_W{1'b0}};
                    busy_s      = 1'b1;
                    state_s     = ST_COUNT;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_COUNT: begin
                if (!bus.start_delay) begin
                    // Abort takes priority over a coincident tick.
                    busy_s     = 1'b0;
                    time_out_s = 1'b0;
                    state_s    = ST_IDLE;
                end else if (bus.tick_ms) begin
                    if (sub_r == SUB_LAST) begin
                        sub_s   = {SCALE_W{1'b0}};
                        units_s = units_r - UNIT_ONE;
                        if (units_r == UNIT_ONE) begin
                            time_out_s = 1'b1;
                            busy_s     = 1'b0;
                            state_s    = ST_DONE;
                        end else begin
                            state_s = ST_COUNT;
                        end
                    end else begin
                        sub_s   = sub_r + {{(SCALE_W-1){1'b0}}, 1'b1};
                        state_s = ST_COUNT;
                    end
                end else begin
                    state_s = ST_COUNT;
                end
            end

            ST_DONE: begin
                if (!bus.start_delay) begin
                    time_out_s = 1'b0;
                    state_s    = ST_IDLE;
                end else begin
                    time_out_s = 1'b1;
                    state_s    = ST_DONE;
                end
            end

            default: begin
                state_s    = ST_IDLE;
                time_out_s = 1'b0;
                busy_s     = 1'b0;
            end
        endcase
    end

    // Controller state, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            units_r     <= {LFSR_W{1'b0}};
            sub_r       <= {SCALE_W{1'b0}};
            time_out_r  <= 1'b0;
            busy_r      <= 1'b0;
            delay_val_r <= {LFSR_W{1'b0}};
        end else begin
            state_r     <= state_s;
            units_r     <= units_s;
            sub_r       <= sub_s;
            time_out_r  <= time_out_s;
            busy_r      <= busy_s;
            delay_val_r <= delay_val_s;
        end
    end

endmodule

// File: tb/tb_random_delay.sv
// Self-checking bench for random_delay: directed scenarios followed by random
// stimulus, all compared against a tick-countdown reference model.
module tb_random_delay;

    localparam int LFSR_W  = 7;
    localparam int SCALE   = 4;
    localparam int SCALE_W = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    random_delay_if #(.LFSR_W(LFSR_W)) bus ();

    random_delay #(
        .LFSR_W (LFSR_W),
        .SEED   (7'h01),
        .SCALE  (SCALE),
        .SCALE_W(SCALE_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: phase 0 idle, 1 counting, 2 expired.
    int m_lfsr;
    int m_start_d;
    int m_phase;
    int m_left;
    int m_to;
    int m_busy;
    int m_delay;

    function automatic int lfsr_step(input int v);
        return ((v << 1) & 127) | (((v >> 6) ^ (v >> 5)) & 1);
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_lfsr    = 1;
        m_start_d = 0;
        m_phase   = 0;
        m_left    = 0;
        m_to      = 0;
        m_busy    = 0;
        m_delay   = 0;
    endtask

    // One clock: drive inputs, advance the model, check outputs after the edge.
    task automatic cycle(input logic t, input logic en, input logic sd);
        bus.tick_ms     = t;
        bus.en_lfsr     = en;
        bus.start_delay = sd;
        case (m_phase)
            0: begin
                m_to = 0;
                if (sd && (m_start_d == 0)) begin
                    m_delay = m_lfsr;
                    m_left  = m_lfsr * SCALE;
                    m_busy  = 1;
                    m_phase = 1;
                end
            end
            1: begin
                if (!sd) begin
                    m_busy  = 0;
                    m_phase = 0;
                end else if (t) begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_to    = 1;
                        m_busy  = 0;
                        m_phase = 2;
                    end
                end
            end
            default: begin
                if (!sd) begin
                    m_to    = 0;
                    m_phase = 0;
                end
            end
        endcase
        m_start_d = sd ? 1 : 0;
        if (en) m_lfsr = lfsr_step(m_lfsr);
        @(posedge clk);
        #1;
        check_val("time_out", {31'd0, bus.time_out}, m_to);
        check_val("busy", {31'd0, bus.busy}, m_busy);
        check_val("delay_val", {25'd0, bus.delay_val}, m_delay);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset();
        bus.tick_ms     = 1'b0;
        bus.en_lfsr     = 1'b0;
        bus.start_delay = 1'b0;
        rst_n = 1'b0;
        #2;
        model_reset();
        check_val("rst_time_out", {31'd0, bus.time_out}, 32'd0);
        check_val("rst_busy", {31'd0, bus.busy}, 32'd0);
        check_val("rst_delay_val", {25'd0, bus.delay_val}, 32'd0);
        #2;
        rst_n = 1'b1;
    endtask

    logic r_sd;
    logic r_t;
    logic r_en;

    initial begin
        bus.tick_ms     = 1'b0;
        bus.en_lfsr     = 1'b0;
        bus.start_delay = 1'b0;
        model_reset();
        #6;
        do_reset();

        // LFSR first step and delay capture of 2 units.
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        check_val("load_delay2", {25'd0, bus.delay_val}, 32'd2);
        check_val("load_busy", {31'd0, bus.busy}, 32'd1);
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 1'b1);
        check_val("tick7_no_timeout", {31'd0, bus.time_out}, 32'd0);
        cycle(1'b1, 1'b0, 1'b1);
        check_val("tick8_timeout", {31'd0, bus.time_out}, 32'd1);
        check_val("tick8_busy", {31'd0, bus.busy}, 32'd0);

        // Hold in DONE, then release.
        for (int i = 0; i < 20; i++) cycle(1'($urandom_range(0, 1)), 1'b0, 1'b1);
        check_val("done_hold", {31'd0, bus.time_out}, 32'd1);
        cycle(1'b0, 1'b0, 1'b0);
        check_val("done_release", {31'd0, bus.time_out}, 32'd0);

        // Two more LFSR steps to 8, then capture coincident with an advance.
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1);
        check_val("capture_pre_adv", {25'd0, bus.delay_val}, 32'd8);

        // Abort after three ticks; time_out must stay low afterwards.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        check_val("abort_busy", {31'd0, bus.busy}, 32'd0);
        for (int i = 0; i < 50; i++) cycle(1'b1, 1'b0, 1'b0);
        check_val("abort_no_timeout", {31'd0, bus.time_out}, 32'd0);

        // New start sees the advanced LFSR value 0x10; abort on a tick edge.
        cycle(1'b0, 1'b0, 1'b1);
        check_val("post_adv_delay", {25'd0, bus.delay_val}, 32'd16);
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0);
        check_val("tick_abort_busy", {31'd0, bus.busy}, 32'd0);
        check_val("tick_abort_to", {31'd0, bus.time_out}, 32'd0);

        // Reset mid-COUNT, then a full delay from SEED, then reset in DONE.
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        do_reset();
        cycle(1'b0, 1'b0, 1'b1);
        check_val("seed_delay", {25'd0, bus.delay_val}, 32'd1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1);
        check_val("seed_tick3", {31'd0, bus.time_out}, 32'd0);
        cycle(1'b1, 1'b0, 1'b1);
        check_val("seed_tick4", {31'd0, bus.time_out}, 32'd1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1);
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);

        // Random traffic against the reference model.
        r_sd = 1'b0;
        for (int i = 0; i < 15000; i++) begin
            if (r_sd) begin
                if ($urandom_range(0, 399) == 0) r_sd = 1'b0;
            end else begin
                if ($urandom_range(0, 9) == 0) r_sd = 1'b1;
            end
            r_t  = 1'($urandom_range(0, 1));
            r_en = 1'($urandom_range(0, 2) == 0);
            cycle(r_t, r_en, r_sd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
